vram_blit_engine: RTL and testbench
===================================

// Module: vram_blit_engine
// PURPOSE
//  Owns VRAM port A of the text-mode display. It muxes it between the Avalon-MM CPU slave and a
//  hardware blit engine that runs FILL (clear screen) and SCROLL_UP (copy rows up one, blank last row).
//  Sits between the Avalon slave decode and the VRAM dual-port RAM; port B stays with the raster logic.
// PARAMETERS
//  WORDS_PER_ROW  40    32-bit VRAM words per text row (2 glyphs/word, 80 cols)
//  ROWS           30    text rows; VRAM span = WORDS_PER_ROW*ROWS = 1200 words
// PORTS
//  CLK             in   1   system clock, 50 MHz
//  RESET           in   1   asynchronous, active-high reset
//  AVL_READ        in   1   Avalon read
//  AVL_WRITE       in   1   Avalon write
//  AVL_CS          in   1   chip select; no access is decoded when low
//  AVL_BYTE_EN     in   4   byte enables
//  AVL_ADDR        in   12  word address: 0x000-0x7FF VRAM, 0xC00-0xC02 engine CSRs
//  AVL_WRITEDATA   in   32  write data
//  AVL_READDATA    out  32  read data
//  AVL_WAITREQUEST out  1   stall
//  VRAM_ADDR       out  11  VRAM port A address
//  VRAM_WDATA      out  32  port A write data
//  VRAM_BE         out  4   port A byte enables
//  VRAM_WE         out  1   port A write enable
//  VRAM_RE         out  1   port A read enable
//  VRAM_Q          in   32  port A read data, valid 1 cycle after VRAM_RE
//  IRQ             out  1   high while STATUS.DONE=1 and CMD.IE=1
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE. FILL=0, CMD=0, DONE=0. Reset mid-blit aborts at once; VRAM
//   contents are left as-is.
//  CSRs (AVL_ADDR[11:10]=2'b11): always served with 0 wait, even while busy.
//   0xC00 CMD W: [0] START (self-clearing), [2:1] OP (00 FILL, 01 SCROLL_UP, 1x ignored), [3] ABORT,
//    [4] IE. A read returns {IE, OP}.
//   0xC01 FILL R/W: 32-bit pattern used for FILL and for the scroll blank row.
//   0xC02 STATUS R: [0] BUSY, [1] DONE. DONE is sticky; it clears on START or on a write of 1 to bit1.
//  Other addresses with bit11=1: read 0, write dropped, no wait.
//  CPU VRAM access while IDLE:
//   - Write: 0 wait; VRAM_WE in the same cycle.
//   - Read: waitrequest=1 in the first cycle with VRAM_RE=1; waitrequest=0 in the second cycle
//     with READDATA=VRAM_Q.
//  While BUSY: all CPU VRAM accesses are held with waitrequest=1 until the cycle after the FSM is IDLE.
//  FSM states: IDLE, FILL, SC_RD, SC_WR, SC_BLANK.
//   - START in IDLE with a valid OP: next cycle enters FILL (ptr=0) or SC_RD (ptr=0), BUSY=1.
//   - FILL: one write of FILL to ptr per cycle, BE=4'hF. At ptr=1199 -> IDLE.
//   - SC_RD: read ptr+WORDS_PER_ROW -> SC_WR. SC_WR: write VRAM_Q to ptr, ptr++.
//     At ptr=(ROWS-1)*WORDS_PER_ROW-1 -> SC_BLANK, otherwise -> SC_RD.
//   - SC_BLANK: writes FILL to ptr=1160..1199, one per cycle -> IDLE.
//   - Leaving for IDLE at completion sets DONE.
//   - Busy length: FILL 1200 cycles; SCROLL 2*1160+40 = 2360 cycles.
//  Boundaries and conflicts:
//   - START while busy: ignored; it does not restart.
//   - START with ABORT=1: ABORT wins.
//   - ABORT while busy: IDLE next cycle with DONE unchanged; no further VRAM writes.
//   - START with OP=1x: ignored; BUSY stays 0.
//   - CPU VRAM write in the same cycle as START: completes first (0 wait), and the engine starts
//     next cycle.
//   - ptr is 11 bits and never exceeds 1199; address arithmetic is unsigned and never wraps.
// TESTING
//  1. Reset: assert RESET mid-FILL -> BUSY=0, DONE=0, VRAM_WE=0 in the same cycle; all outputs 0.
//  2. FILL=0x00200020, CMD=0x01 -> BUSY for 1200 cycles; every word reads 0x00200020; DONE=1.
//  3. Preload word i=i, FILL=0, CMD=0x03 -> after 2360 cycles word i=i+40 for i<1160,
//     words 1160-1199 = 0, DONE=1.
//  4. During SCROLL, CPU read of 0x005 -> waitrequest held until after done;
//     returns the post-scroll value 0x2D.
//  5. FILL started; after 100 cycles write CMD=0x08 -> BUSY=0 next cycle; word 99 holds the
//     pattern, word 100 is unchanged, DONE=0.
//  6. CMD=0x11 with IE=1 -> IRQ=1 at completion; write STATUS bit1=1 -> IRQ=0;
//     CMD=0x05 (OP=10) -> no activity.

Source files
------------

// File: rtl/vram_blit_engine_if.sv
// Avalon-MM CPU slave and VRAM port A signals of the text-mode blit engine, grouped.
// slave is the engine's view; master is the bus / RAM side that drives requests and read data.
interface vram_blit_engine_if;
    logic        avl_read;
    logic        avl_write;
    logic        avl_cs;
    logic [3:0]  avl_byte_en;
    logic [11:0] avl_addr;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;
    logic        avl_waitrequest;
    logic [10:0] vram_addr;
    logic [31:0] vram_wdata;
    logic [3:0]  vram_be;
    logic        vram_we;
    logic        vram_re;
    logic [31:0] vram_q;
    logic        irq;

    modport slave (
        input  avl_read, avl_write, avl_cs, avl_byte_en, avl_addr, avl_writedata, vram_q,
        output avl_readdata, avl_waitrequest, vram_addr, vram_wdata, vram_be, vram_we, vram_re, irq
    );

    modport master (
        output avl_read, avl_write, avl_cs, avl_byte_en, avl_addr, avl_writedata, vram_q,
        input  avl_readdata, avl_waitrequest, vram_addr, vram_wdata, vram_be, vram_we, vram_re, irq
    );
endinterface

// File: rtl/vram_blit_engine.sv
// Owns VRAM port A: arbitrates between CPU Avalon accesses and a FILL / SCROLL_UP blit engine.
// CSRs live at 0xC00-0xC02 and are always answered with zero wait, even while a blit runs.
module vram_blit_engine #(
    parameter int WORDS_PER_ROW = 40,
    parameter int ROWS          = 30
) (
    input logic               clk,
    input logic               rst,
    vram_blit_engine_if.slave bus
);
    localparam logic [10:0] LAST_WORD  = 11'(WORDS_PER_ROW * ROWS - 1);
    localparam logic [10:0] LAST_COPY  = 11'((ROWS - 1) * WORDS_PER_ROW - 1);
    localparam logic [10:0] ROW_STRIDE = 11'(WORDS_PER_ROW);

    typedef enum logic [2:0] {IDLE, FILL, SC_RD, SC_WR, SC_BLANK} state_t;

    state_t      state, state_next;
    logic [10:0] ptr, ptr_next;
    logic [31:0] fill;
    logic [1:0]  op;
    logic        ie;
    logic        done;
    logic        rd_pend;
    logic        busy;

    logic        access, csr_sel, csr_hit, vram_sel;
    logic        cmd_wr, fill_wr, status_wr;
    logic        abort_req, start_req, start_go, done_clr;
    logic        cpu_idle, cpu_wr, cpu_rd;
    logic        eng_we, eng_re, finish;
    logic [10:0] eng_addr;
    logic [31:0] eng_wdata;
    logic [31:0] csr_rdata;

    assign busy     = (state != IDLE);
    assign access   = bus.avl_cs & (bus.avl_read | bus.avl_write);
    assign csr_sel  = access & (bus.avl_addr[11:10] == 2'b11);
    assign csr_hit  = (bus.avl_addr[9:2] == 8'h00);
    assign vram_sel = access & ~bus.avl_addr[11];

    assign cmd_wr    = csr_sel & bus.avl_write & csr_hit & (bus.avl_addr[1:0] == 2'd0);
    assign fill_wr   = csr_sel & bus.avl_write & csr_hit & (bus.avl_addr[1:0] == 2'd1);
    assign status_wr = csr_sel & bus.avl_write & csr_hit & (bus.avl_addr[1:0] == 2'd2);

    // ABORT beats START in the same write; OP=1x is not a command
    assign abort_req = cmd_wr & bus.avl_writedata[3];
    assign start_req = cmd_wr & bus.avl_writedata[0] & ~bus.avl_writedata[3] & ~bus.avl_writedata[2];
    assign start_go  = start_req & ~busy;
    assign done_clr  = status_wr & bus.avl_writedata[1];

    assign cpu_idle = ~busy;
    assign cpu_wr   = vram_sel & bus.avl_write & cpu_idle;
    assign cpu_rd   = vram_sel & ~bus.avl_write & bus.avl_read & cpu_idle;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        eng_we     = 1'b0;
        eng_re     = 1'b0;
        eng_addr   = ptr;
        eng_wdata  = fill;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_go) begin
                    ptr_next   = '0;
                    state_next = bus.avl_writedata[1] ? SC_RD : FILL;
                end
            end
            FILL, SC_BLANK: begin
                eng_we = 1'b1;
                if (ptr == LAST_WORD) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end else begin
                    ptr_next = ptr + 11'd1;
                end
            end
            SC_RD: begin
                eng_re     = 1'b1;
                eng_addr   = ptr + ROW_STRIDE;
                state_next = SC_WR;
            end
            SC_WR: begin
                eng_we     = 1'b1;
                eng_wdata  = bus.vram_q;
                ptr_next   = ptr + 11'd1;
                state_next = (ptr == LAST_COPY) ? SC_BLANK : SC_RD;
            end
            default: state_next = IDLE;
        endcase
        // an abort drops the access of this very cycle, so nothing lands after the CMD write
        if (abort_req && busy) begin
            state_next = IDLE;
            eng_we     = 1'b0;
            eng_re     = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            fill    <= '0;
            op      <= '0;
            ie      <= 1'b0;
            done    <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            rd_pend <= cpu_rd & ~rd_pend;
            if (fill_wr)
                fill <= bus.avl_writedata;
            if (cmd_wr) begin
                op <= bus.avl_writedata[2:1];
                ie <= bus.avl_writedata[4];
            end
            if (finish)
                done <= 1'b1;
            else if (start_go || done_clr)
                done <= 1'b0;
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_hit) begin
            case (bus.avl_addr[1:0])
                2'd0:    csr_rdata = {29'b0, ie, op};
                2'd1:    csr_rdata = fill;
                2'd2:    csr_rdata = {30'b0, done, busy};
                default: csr_rdata = '0;
            endcase
        end
    end

    // outputs are forced low for as long as reset is held
    always_comb begin
        bus.avl_readdata    = '0;
        bus.avl_waitrequest = 1'b0;
        bus.vram_addr       = '0;
        bus.vram_wdata      = '0;
        bus.vram_be         = '0;
        bus.vram_we         = 1'b0;
        bus.vram_re         = 1'b0;
        bus.irq             = 1'b0;
        if (!rst) begin
            bus.irq = done & ie;
            if (busy) begin
                bus.vram_addr  = eng_addr;
                bus.vram_wdata = eng_wdata;
                bus.vram_be    = eng_we ? 4'hF : 4'h0;
                bus.vram_we    = eng_we;
                bus.vram_re    = eng_re;
            end else if (cpu_wr) begin
                bus.vram_addr  = bus.avl_addr[10:0];
                bus.vram_wdata = bus.avl_writedata;
                bus.vram_be    = bus.avl_byte_en;
                bus.vram_we    = 1'b1;
            end else if (cpu_rd) begin
                bus.vram_addr = bus.avl_addr[10:0];
                bus.vram_re   = ~rd_pend;
            end
            if (vram_sel) begin
                if (!cpu_idle)
                    bus.avl_waitrequest = 1'b1;
                else if (cpu_rd) begin
                    bus.avl_waitrequest = ~rd_pend;
                    bus.avl_readdata    = rd_pend ? bus.vram_q : 32'h0;
                end
            end
            if (csr_sel && bus.avl_read && !bus.avl_write)
                bus.avl_readdata = csr_rdata;
        end
    end
endmodule

// File: tb/tb_vram_blit_engine.sv
// Bench for vram_blit_engine: behavioural VRAM on port A, a shadow copy of VRAM contents,
// and an in-order scoreboard of expected CPU read data.
module tb_vram_blit_engine;
    localparam int WPR   = 40;
    localparam int NROWS = 30;
    localparam int SPAN  = WPR * NROWS;
    localparam int LIMIT = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vram_blit_engine_if bus();

    vram_blit_engine #(.WORDS_PER_ROW(WPR), .ROWS(NROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] vram   [0:2047];
    logic [31:0] shadow [0:SPAN-1];
    logic [31:0] sb [$];
    int vectors     = 0;
    int miscompares = 0;

    always @(posedge clk) begin
        if (bus.vram_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.vram_be[b]) vram[bus.vram_addr][8*b +: 8] <= bus.vram_wdata[8*b +: 8];
        end
        if (bus.vram_re) bus.vram_q <= vram[bus.vram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // all bus tasks start and end on a falling edge
    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        bus.avl_cs = 1'b1; bus.avl_write = 1'b1; bus.avl_addr = a;
        bus.avl_writedata = d; bus.avl_byte_en = be;
        #1;
        while (bus.avl_waitrequest && n < LIMIT) begin @(negedge clk); #1; n++; end
        if (n >= LIMIT) chk("wr_waitrequest", {31'b0, bus.avl_waitrequest}, 32'h0);
        @(negedge clk);
        bus.avl_cs = 1'b0; bus.avl_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [11:0] a, output logic [31:0] d, output int waits);
        int n = 0;
        bus.avl_cs = 1'b1; bus.avl_read = 1'b1; bus.avl_addr = a;
        #1;
        while (bus.avl_waitrequest && n < LIMIT) begin @(negedge clk); #1; n++; end
        if (n >= LIMIT) chk("rd_waitrequest", {31'b0, bus.avl_waitrequest}, 32'h0);
        d = bus.avl_readdata;
        waits = n;
        @(negedge clk);
        bus.avl_cs = 1'b0; bus.avl_read = 1'b0;
    endtask

    task automatic rd_exp(input logic [11:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        int w;
        sb.push_back(exp);
        bus_rd(a, got, w);
        chk(tag, got, sb.pop_front());
    endtask

    task automatic verify_all(input string tag);
        for (int i = 0; i < SPAN; i++) rd_exp(12'(i), shadow[i], $sformatf("%s_w%0d", tag, i));
    endtask

    task automatic poll_busy(output int busy_cycles, output logic [31:0] st);
        int w;
        busy_cycles = 0;
        bus_rd(12'hC02, st, w);
        while (st[0] && busy_cycles < 5000) begin
            busy_cycles++;
            bus_rd(12'hC02, st, w);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, st;
        int w, nb;
        bus.avl_cs = 1'b0; bus.avl_read = 1'b0; bus.avl_write = 1'b0;
        bus.avl_addr = '0; bus.avl_writedata = '0; bus.avl_byte_en = 4'h0;

        // outputs stay low under reset even with a CPU write presented
        #1;
        chk("rst_readdata", bus.avl_readdata, 32'h0);
        chk("rst_irq", {31'b0, bus.irq}, 32'h0);
        bus.avl_cs = 1'b1; bus.avl_write = 1'b1; bus.avl_addr = 12'h010;
        bus.avl_writedata = 32'hDEAD_BEEF; bus.avl_byte_en = 4'hF;
        #1;
        chk("rst_we", {31'b0, bus.vram_we}, 32'h0);
        chk("rst_addr", {21'b0, bus.vram_addr}, 32'h0);
        chk("rst_wdata", bus.vram_wdata, 32'h0);
        chk("rst_wreq", {31'b0, bus.avl_waitrequest}, 32'h0);
        bus.avl_cs = 1'b0; bus.avl_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        rd_exp(12'hC02, 32'h0, "init_status");
        rd_exp(12'hC00, 32'h0, "init_cmd");
        rd_exp(12'hC01, 32'h0, "init_fill");
        bus_rd(12'h800, got, w);
        chk("hole_rd", got, 32'h0);
        chk("hole_wait", 32'(w), 32'h0);
        rd_exp(12'hC03, 32'h0, "csr_hole_rd");

        // FILL
        bus_wr(12'hC01, 32'h0020_0020, 4'hF);
        rd_exp(12'hC01, 32'h0020_0020, "fill_reg");
        bus_wr(12'hC00, 32'h01, 4'hF);
        poll_busy(nb, st);
        chk("fill_busy_len", 32'(nb), 32'd1200);
        chk("fill_status", st, 32'h2);
        for (int i = 0; i < SPAN; i++) shadow[i] = 32'h0020_0020;
        verify_all("fill");

        // reset in the middle of a FILL (same pattern, contents unaffected)
        bus_wr(12'hC00, 32'h01, 4'hF);
        repeat (20) @(negedge clk);
        chk("pre_rst_we", {31'b0, bus.vram_we}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_we", {31'b0, bus.vram_we}, 32'h0);
        chk("midrst_addr", {21'b0, bus.vram_addr}, 32'h0);
        chk("midrst_be", {28'b0, bus.vram_be}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_exp(12'hC02, 32'h0, "midrst_status");
        rd_exp(12'hC01, 32'h0, "midrst_fill");

        // preload word i = i, then SCROLL_UP with a CPU read held across it
        for (int i = 0; i < SPAN; i++) begin
            bus_wr(12'(i), 32'(i), 4'hF);
            shadow[i] = 32'(i);
        end
        bus_wr(12'hC01, 32'h0, 4'hF);
        bus_wr(12'hC00, 32'h03, 4'hF);
        for (int i = 0; i < SPAN; i++) shadow[i] = (i < SPAN - WPR) ? shadow[i + WPR] : 32'h0;
        sb.push_back(shadow[5]);
        bus_rd(12'h005, got, w);
        chk("scroll_cpu_rd", got, sb.pop_front());
        chk("scroll_hold", 32'(w), 32'd2361);
        rd_exp(12'hC02, 32'h2, "scroll_status");
        rd_exp(12'hC00, 32'h1, "scroll_cmd");
        verify_all("scroll");

        // idle read latency, partial byte write, dropped hole write
        bus_rd(12'h007, got, w);
        chk("idle_rd_wait", 32'(w), 32'd1);
        chk("idle_rd_data", got, shadow[7]);
        bus_wr(12'h005, 32'hFFFF_FFFF, 4'b0011);
        shadow[5] = {shadow[5][31:16], 16'hFFFF};
        rd_exp(12'h005, shadow[5], "byte_en");
        bus_wr(12'h905, 32'h1234_5678, 4'hF);
        rd_exp(12'h105, shadow[261], "hole_wr");

        // FILL interrupted by an ignored START, then ABORT on the cycle that would write word 100
        bus_wr(12'hC01, 32'hA5A5_5A5A, 4'hF);
        bus_wr(12'hC00, 32'h01, 4'hF);
        repeat (49) @(negedge clk);
        bus_wr(12'hC00, 32'h03, 4'hF);
        repeat (50) @(negedge clk);
        bus_wr(12'hC00, 32'h08, 4'hF);
        chk("abort_we", {31'b0, bus.vram_we}, 32'h0);
        rd_exp(12'hC02, 32'h0, "abort_status");
        for (int i = 0; i < 100; i++) shadow[i] = 32'hA5A5_5A5A;
        rd_exp(12'h000, shadow[0], "abort_w0");
        rd_exp(12'h063, shadow[99], "abort_w99");
        rd_exp(12'h064, shadow[100], "abort_w100");
        rd_exp(12'h065, shadow[101], "abort_w101");

        // interrupt enable, DONE clear, invalid OP, START with ABORT
        bus_wr(12'hC01, 32'h0F0F_0F0F, 4'hF);
        bus_wr(12'hC00, 32'h11, 4'hF);
        chk("irq_busy", {31'b0, bus.irq}, 32'h0);
        poll_busy(nb, st);
        chk("irq_busy_len", 32'(nb), 32'd1200);
        chk("irq_done", {31'b0, bus.irq}, 32'h1);
        rd_exp(12'hC00, 32'h4, "cmd_ie");
        bus_wr(12'hC02, 32'h2, 4'hF);
        chk("irq_clear", {31'b0, bus.irq}, 32'h0);
        rd_exp(12'hC02, 32'h0, "done_clear");
        bus_wr(12'hC00, 32'h05, 4'hF);
        chk("op2_we", {31'b0, bus.vram_we}, 32'h0);
        rd_exp(12'hC02, 32'h0, "op2_status");
        bus_wr(12'hC00, 32'h09, 4'hF);
        chk("startabort_we", {31'b0, bus.vram_we}, 32'h0);
        rd_exp(12'hC02, 32'h0, "startabort_status");
        for (int i = 0; i < SPAN; i++) shadow[i] = 32'h0F0F_0F0F;
        rd_exp(12'h000, shadow[0], "ie_fill_w0");
        rd_exp(12'h258, shadow[600], "ie_fill_w600");
        rd_exp(12'h4AF, shadow[1199], "ie_fill_w1199");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
